// File: rtl/beat_metronome.sv
// Tick-driven tempo generator: beat/downbeat/colour strobes with handshaked tempo/meter config.
// Latency: pulses registered, high the cycle after the edge that samples the terminal trigger.
// Backpressure: cfg_ready low while a config is pending; it is applied at a beat boundary, in IDLE, or on restart.
// Optional half-beat subdivision strobe: define BEAT_METRONOME_SUBDIV_EN.
module beat_metronome #(
    parameter int CNT_W          = 8,
    parameter int BEAT_W         = 3,
    parameter int DEFAULT_PERIOD = 30,
    parameter int DEFAULT_BEATS  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              trigger,
    input  logic              enable,
    input  logic              restart,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [BEAT_W-1:0] beats_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              color,
    output logic              beat_pulse,
    output logic              downbeat_pulse,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              sub_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [BEAT_W-1:0] r_beats;
    logic [BEAT_W-1:0] r_beat_idx;
    logic              r_color;
    logic              r_beat_pulse;
    logic              r_down_pulse;

    logic              r_pend_vld;
    logic [CNT_W-1:0]  r_pend_period;
    logic [BEAT_W-1:0] r_pend_beats;

    logic              w_count;
    logic              w_terminal;
    logic              w_idx_wrap;
    logic              w_apply;
    logic              w_take;
    logic [CNT_W-1:0]  w_period_san;
    logic [BEAT_W-1:0] w_beats_san;

    // A trigger only counts while running; restart and a dropping enable both swallow it.
    assign w_count    = (r_state == ST_RUN) & enable & trigger & ~restart;
    assign w_terminal = w_count & (r_cnt == r_period - CNT_W'(1));
    // >= rather than == keeps the index bounded if a smaller meter landed mid-measure.
    assign w_idx_wrap = (r_beat_idx >= r_beats - BEAT_W'(1));

    assign w_apply = r_pend_vld & (restart | w_terminal | (r_state == ST_IDLE));
    assign w_take  = cfg_valid & ~r_pend_vld;

    assign w_period_san = (period_in == '0) ? CNT_W'(1)  : period_in;
    assign w_beats_san  = (beats_in  == '0) ? BEAT_W'(1) : beats_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = enable ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (enable)  w_state_nxt = ST_RUN;
                ST_RUN:    if (!enable) w_state_nxt = ST_PAUSED;
                ST_PAUSED: if (enable)  w_state_nxt = ST_RUN;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt        <= '0;
            r_beat_idx   <= '0;
            r_color      <= 1'b0;
            r_beat_pulse <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_beat_pulse <= 1'b0;
            r_down_pulse <= 1'b0;
            if (restart) begin
                r_cnt      <= '0;
                r_beat_idx <= '0;
                r_color    <= 1'b0;
            end else if (w_terminal) begin
                r_cnt        <= '0;
                r_color      <= ~r_color;
                r_beat_pulse <= 1'b1;
                r_beat_idx   <= w_idx_wrap ? '0 : r_beat_idx + BEAT_W'(1);
                r_down_pulse <= w_idx_wrap;
            end else if (w_count) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Period only ever changes together with counter==0, so the count never overruns it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_period      <= CNT_W'(DEFAULT_PERIOD);
            r_beats       <= BEAT_W'(DEFAULT_BEATS);
            r_pend_vld    <= 1'b0;
            r_pend_period <= '0;
            r_pend_beats  <= '0;
        end else if (w_apply) begin
            r_period   <= r_pend_period;
            r_beats    <= r_pend_beats;
            r_pend_vld <= 1'b0;
        end else if (w_take) begin
            r_pend_vld    <= 1'b1;
            r_pend_period <= w_period_san;
            r_pend_beats  <= w_beats_san;
        end
    end

`ifdef BEAT_METRONOME_SUBDIV_EN
    logic r_sub_pulse;
    logic w_half_hit;

    assign w_half_hit = w_count & ~w_terminal & (r_period >= CNT_W'(2)) &
                        ((r_cnt + CNT_W'(1)) == (r_period >> 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sub_pulse <= 1'b0;
        end else begin
            r_sub_pulse <= w_terminal | w_half_hit;
        end
    end

    assign sub_pulse = r_sub_pulse;
`else
    assign sub_pulse = 1'b0;
`endif

    assign cfg_ready      = ~r_pend_vld;
    assign color          = r_color;
    assign beat_pulse     = r_beat_pulse;
    assign downbeat_pulse = r_down_pulse;
    assign beat_idx       = r_beat_idx;

endmodule

// File: tb/tb_beat_metronome.sv
// Randomised self-checking bench for beat_metronome against a tick-counting reference model.
module tb_beat_metronome;
    localparam int CNT_W  = 8;
    localparam int BEAT_W = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;
`ifdef BEAT_METRONOME_SUBDIV_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in, trigger, enable, restart, cfg_valid;
    logic [CNT_W-1:0]  period_in;
    logic [BEAT_W-1:0] beats_in;
    logic              cfg_ready, color, beat_pulse, downbeat_pulse, sub_pulse;
    logic [BEAT_W-1:0] beat_idx;

    int n_vec = 0;
    int n_err = 0;

    // reference model: ticks elapsed in the current beat, beat number in the measure
    int m_mode, m_cnt, m_idx, m_per, m_bts, m_pper, m_pbts;
    bit m_color, m_bp, m_dp, m_sp, m_pend;

    beat_metronome dut (
        .clk_in(clk_in), .rst_in(rst_in), .trigger(trigger), .enable(enable),
        .restart(restart), .period_in(period_in), .beats_in(beats_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .color(color),
        .beat_pulse(beat_pulse), .downbeat_pulse(downbeat_pulse),
        .beat_idx(beat_idx), .sub_pulse(sub_pulse)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] obs();
        return {cfg_ready, color, beat_pulse, downbeat_pulse, beat_idx, sub_pulse};
    endfunction

    function automatic logic [7:0] expv();
        return {!m_pend, m_color, m_bp, m_dp, BEAT_W'(m_idx), m_sp};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_idx = 0; m_color = 0;
        m_bp = 0; m_dp = 0; m_sp = 0;
        m_per = 30; m_bts = 4; m_pend = 0; m_pper = 0; m_pbts = 0;
    endtask

    task automatic model_step();
        bit counted, apply;
        m_bp = 0; m_dp = 0; m_sp = 0;
        counted = (m_mode == M_RUN) && enable && trigger && !restart;
        apply = m_pend && (restart || m_mode == M_IDLE || (counted && m_cnt + 1 == m_per));
        if (restart) begin
            m_cnt = 0; m_idx = 0; m_color = 0;
        end else if (counted) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == m_per) begin
                m_cnt = 0; m_color = !m_color; m_bp = 1;
                m_idx = (m_idx + 1 >= m_bts) ? 0 : m_idx + 1;
                m_dp = (m_idx == 0);
                m_sp = SUB;
            end else if (SUB && m_per >= 2 && m_cnt == m_per / 2) begin
                m_sp = 1;
            end
        end
        if (apply) begin
            m_per = m_pper; m_bts = m_pbts; m_pend = 0;
        end else if (cfg_valid && !m_pend) begin
            m_pend = 1;
            m_pper = (period_in == 0) ? 1 : int'(period_in);
            m_pbts = (beats_in == 0) ? 1 : int'(beats_in);
        end
        if (restart)                          m_mode = enable ? M_RUN : M_IDLE;
        else if (m_mode == M_IDLE && enable)  m_mode = M_RUN;
        else if (m_mode == M_RUN && !enable)  m_mode = M_PAUSED;
        else if (m_mode == M_PAUSED && enable) m_mode = M_RUN;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_cfg(input int per, input int bts);
        enable = 0; restart = 1; tick(); restart = 0;
        period_in = CNT_W'(per); beats_in = BEAT_W'(bts); cfg_valid = 1; tick(); cfg_valid = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1; trigger = 0; enable = 0; restart = 0; cfg_valid = 0;
        period_in = '0; beats_in = '0;
        model_reset();
        #12;
        n_vec++;
        if (obs() !== 8'b1000_0000) begin
            n_err++; $display("FAIL reset_state: got %b expected %b", obs(), 8'b1000_0000);
        end
        @(negedge clk_in); rst_in = 0; tick();
    endtask

    task automatic test_default_run();
        int nb = 0, nd = 0;
        enable = 1; tick();
        for (int t = 1; t <= 120; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL default_run t=%0d: got %b expected %b", t, obs(), expv()); end
            if (beat_pulse === 1'b1) begin
                nb++;
                n_vec++;
                if (t != nb * 30 || color !== nb[0] || beat_idx !== BEAT_W'(nb % 4)) begin
                    n_err++; $display("FAIL default_beat: got t=%0d color=%b idx=%0d expected t=%0d color=%b idx=%0d", t, color, beat_idx, nb*30, nb[0], nb%4);
                end
            end
            if (downbeat_pulse === 1'b1) begin
                nd++;
                n_vec++;
                if (t != 120) begin n_err++; $display("FAIL default_downbeat: got t=%0d expected t=120", t); end
            end
            repeat ($urandom_range(0, 2)) begin
                tick(); n_vec++;
                if (obs() !== expv()) begin n_err++; $display("FAIL default_gap: got %b expected %b", obs(), expv()); end
            end
        end
        n_vec++;
        if (nb != 4 || nd != 1) begin n_err++; $display("FAIL default_counts: got beats=%0d downs=%0d expected 4 and 1", nb, nd); end
    endtask

    task automatic test_cfg_midbeat();
        int nb = 0, nd = 0;
        for (int t = 1; t <= 10; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL cfg_pre: got %b expected %b", obs(), expv()); end
        end
        period_in = 8'd5; beats_in = 3'd3; cfg_valid = 1; tick();
        period_in = 8'd9; beats_in = 3'd7; tick(); cfg_valid = 0;
        n_vec++;
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL cfg_ready_drop: got %b expected 0", cfg_ready); end
        for (int t = 11; t <= 30; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL cfg_wait t=%0d: got %b expected %b", t, obs(), expv()); end
            n_vec++;
            if ({beat_pulse, cfg_ready} !== ((t == 30) ? 2'b11 : 2'b00)) begin
                n_err++; $display("FAIL cfg_boundary t=%0d: got beat,ready=%b%b expected %0d", t, beat_pulse, cfg_ready, (t == 30) ? 3 : 0);
            end
        end
        for (int t = 1; t <= 15; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL cfg_new t=%0d: got %b expected %b", t, obs(), expv()); end
            if (beat_pulse === 1'b1) nb++;
            if (downbeat_pulse === 1'b1) nd++;
            n_vec++;
            if (beat_pulse !== (t % 5 == 0)) begin n_err++; $display("FAIL cfg_period5 t=%0d: got %b expected %b", t, beat_pulse, t % 5 == 0); end
        end
        n_vec++;
        if (nb != 3 || nd != 1) begin n_err++; $display("FAIL cfg_counts: got beats=%0d downs=%0d expected 3 and 1", nb, nd); end
    endtask

    task automatic test_zero_cfg();
        enable = 0; restart = 1; tick(); restart = 0;
        period_in = '0; beats_in = '0; cfg_valid = 1; tick(); cfg_valid = 0;
        n_vec++;
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL zero_take: got ready=%b expected 0", cfg_ready); end
        tick();
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL zero_idle_apply: got ready=%b expected 1", cfg_ready); end
        enable = 1; tick();
        for (int t = 1; t <= 8; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if ({beat_pulse, downbeat_pulse, beat_idx} !== {2'b11, BEAT_W'(0)} || obs() !== expv()) begin
                n_err++; $display("FAIL zero_beat t=%0d: got %b expected %b", t, obs(), expv());
            end
            tick(); n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL zero_gap: got %b expected %b", obs(), expv()); end
        end
    endtask

    task automatic test_pause();
        logic c0;
        int k;
        load_cfg(30, 4);
        enable = 1; tick();
        for (int t = 1; t <= 12; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL pause_pre: got %b expected %b", obs(), expv()); end
        end
        c0 = color;
        enable = 0;
        for (int t = 1; t <= 50; t++) begin
            trigger = 1; tick(); trigger = 0; tick();
            n_vec++;
            if (obs() !== expv() || color !== c0 || beat_pulse !== 1'b0) begin
                n_err++; $display("FAIL pause_hold: got %b expected %b", obs(), expv());
            end
        end
        enable = 1; tick();
        k = 0;
        while (k < 40) begin
            trigger = 1; tick(); trigger = 0; k++;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL pause_resume: got %b expected %b", obs(), expv()); end
            if (beat_pulse === 1'b1) break;
        end
        n_vec++;
        if (k != 18) begin n_err++; $display("FAIL pause_remaining: got %0d triggers expected 18", k); end
    endtask

    task automatic test_restart();
        int k;
        period_in = 8'd6; beats_in = 3'd2; cfg_valid = 1; tick(); cfg_valid = 0;
        k = 0;
        while (m_cnt != 29 && k < 60) begin
            trigger = 1; tick(); trigger = 0; k++;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL restart_pre: got %b expected %b", obs(), expv()); end
        end
        restart = 1; trigger = 1; tick(); restart = 0; trigger = 0;
        n_vec++;
        if ({cfg_ready, color, beat_pulse, downbeat_pulse, beat_idx} !== {4'b1000, BEAT_W'(0)}) begin
            n_err++; $display("FAIL restart_collide: got %b expected 1000000", {cfg_ready, color, beat_pulse, downbeat_pulse, beat_idx});
        end
        for (int t = 1; t <= 12; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (beat_pulse !== (t % 6 == 0) || obs() !== expv()) begin
                n_err++; $display("FAIL restart_newcfg t=%0d: got %b expected %b", t, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        for (int t = 1; t <= 3; t++) begin trigger = 1; tick(); trigger = 0; end
        period_in = 8'd3; beats_in = 3'd3; cfg_valid = 1; tick(); cfg_valid = 0;
        #2 rst_in = 1; model_reset();
        #1;
        n_vec++;
        if (obs() !== 8'b1000_0000) begin n_err++; $display("FAIL reset_mid: got %b expected %b", obs(), 8'b1000_0000); end
        @(negedge clk_in); rst_in = 0; tick();
        k = 0;
        while (k < 40) begin
            trigger = 1; tick(); trigger = 0; k++;
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL reset_after: got %b expected %b", obs(), expv()); end
            if (beat_pulse === 1'b1) break;
        end
        n_vec++;
        if (k != 30) begin n_err++; $display("FAIL reset_first_beat: got %0d triggers expected 30", k); end
    endtask

    task automatic test_subdiv();
        load_cfg(7, 4);
        enable = 1; tick();
        for (int t = 1; t <= 14; t++) begin
            trigger = 1; tick(); trigger = 0;
            n_vec++;
            if (sub_pulse !== (SUB && (t % 7 == 3 || t % 7 == 0)) || obs() !== expv()) begin
                n_err++; $display("FAIL subdiv t=%0d: got sub=%b all=%b expected all=%b", t, sub_pulse, obs(), expv());
            end
            tick(); n_vec++;
            if (sub_pulse !== 1'b0) begin n_err++; $display("FAIL subdiv_gap: got %b expected 0", sub_pulse); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            trigger   = ($urandom % 2) == 0;
            enable    = ($urandom % 16) != 0;
            restart   = ($urandom % 80) == 0;
            cfg_valid = ($urandom % 10) == 0;
            period_in = CNT_W'($urandom_range(0, 12));
            beats_in  = BEAT_W'($urandom);
            tick();
            n_vec++;
            if (obs() !== expv()) begin n_err++; $display("FAIL random c=%0d: got %b expected %b", c, obs(), expv()); end
        end
        trigger = 0; restart = 0; cfg_valid = 0;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_cfg_midbeat();
        test_zero_cfg();
        test_pause();
        test_restart();
        test_reset_mid();
        test_subdiv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
